axi4_instr_q: RTL and testbench
===============================

AXI4_INSTR_Q -- requirements
Module: axi4_instr_q

Interface
REQ-001 The module SHALL have parameter SLOTS, default 4, meaning DDR command slots per stream beat (1..8).
REQ-002 The module SHALL have parameters BG_WIDTH 2, BANK_WIDTH 2, COL_WIDTH 10, ROW_WIDTH 17, giving DDR address field widths.
REQ-003 The module SHALL have parameter FIFO_DEPTH, default 8, meaning beat buffer depth (power of two, >=2).
REQ-004 The module SHALL support only parameter sets with 3+BANK_WIDTH+BG_WIDTH+max(ROW_WIDTH,COL_WIDTH+2) <= 32.
REQ-005 Ports SHALL be (name direction width meaning), with one clock and a synchronous, active-low reset:
  clk  in  1  sole clock, all logic on rising edge
  rst_n  in  1  synchronous active-low reset
  S_AXIS_TDATA  in  32*SLOTS  instruction beat, slot i at bits [32i+31:32i]
  S_AXIS_TVALID  in  1  beat valid
  S_AXIS_TREADY  out  1  buffer can accept
  issue_en  in  1  permit popping/issuing buffered beats
  fifo_level  out  clog2(FIFO_DEPTH)+1  buffered beat count
  wait_busy  out  1  WAIT countdown active
  latest_instr_id  out  3  slot-0 opcode of last issued beat
  ddr_write, ddr_read, ddr_pre, ddr_act, ddr_ref, ddr_zq, ddr_nop, ddr_ap, ddr_half_bl, ddr_pall  out  SLOTS each  per-slot command flags
  ddr_bg/ddr_bank/ddr_col/ddr_row  out  SLOTS*BG/BANK/COL/ROW_WIDTH  per-slot addresses, slot i in lane i

Function
REQ-006 Slot format SHALL be: op=[2:0]; bank=[3 +: BANK]; bg=[3+BANK +: BG]; A=3+BANK+BG; row=[A +: ROW]; col=[A +: COL]; pall=[A]; ap=[A+COL]; half_bl=[A+COL+1]; wait_cnt=[18:3].
REQ-007 Opcodes SHALL decode as 0 NOP, 1 PRE, 2 ACT, 3 RD, 4 WR, 5 REF, 6 ZQ, 7 WAIT.
REQ-008 A beat SHALL be pushed into the FIFO when S_AXIS_TVALID and S_AXIS_TREADY are both high at a rising edge.
REQ-009 S_AXIS_TREADY SHALL equal (fifo_level != FIFO_DEPTH), with no pop-based lookahead; when full, no push occurs even if a pop occurs in the same cycle.
REQ-010 A pop SHALL occur when issue_en=1, FIFO non-empty, and the wait counter = 0; push and pop in the same cycle SHALL leave fifo_level unchanged.
REQ-011 All ddr_* outputs SHALL be registered and update every cycle; a popped beat SHALL appear on the outputs at the edge after the pop, so a beat pushed into an empty FIFO at edge t is driven after edge t+2.
REQ-012 For each slot of an issued beat, exactly one of write/read/pre/act/ref/zq/nop SHALL be 1; WAIT slots SHALL drive nop=1.
REQ-013 ddr_pall SHALL be the pall bit only for PRE slots, ddr_ap and ddr_half_bl only for RD/WR slots, and 0 otherwise.
REQ-014 ddr_bank/bg/row/col SHALL carry the slot fields for every opcode except NOP and WAIT, which SHALL drive 0.
REQ-015 In every cycle without a pop (empty, issue_en=0, or WAIT active), the outputs SHALL present an idle beat: ddr_nop all ones, all other outputs 0.
REQ-016 On popping a beat containing WAIT slots, the 16-bit wait counter SHALL load wait_cnt of the highest-index WAIT slot; wait_cnt=0 SHALL insert nothing.
REQ-017 While the wait counter is nonzero, wait_busy SHALL be 1, the counter SHALL decrement by one per cycle regardless of issue_en, and no pop SHALL occur, giving exactly wait_cnt idle beats before the next issue.
REQ-018 latest_instr_id SHALL update to the slot-0 opcode only on an issued beat and hold during idle beats.
REQ-019 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL stay within 0..FIFO_DEPTH.

Reset
REQ-020 While rst_n=0 at a clock edge, the module SHALL clear the FIFO (level 0), the wait counter, wait_busy and latest_instr_id, and drive the idle beat (ddr_nop all ones, all else 0).
REQ-021 S_AXIS_TREADY SHALL be 0 while rst_n=0 and 1 at the first edge after release.
REQ-022 Reset asserted mid-WAIT or with a non-empty FIFO SHALL discard all buffered beats and the remaining wait count.

Verification
REQ-023 Reset, then push one beat with slot0=ACT bank2 bg1 row 0x1ABCD and slot1=RD col 0x155 ap=1 -> outputs 2 edges after the push show act[0]=1, read[1]=1, ap[1]=1, nop[3:2]=2'b11.
REQ-024 Hold issue_en=0 and push 9 beats with TVALID=1 -> TREADY drops after 8 accepted, fifo_level=8; set issue_en=1 -> 8 beats issued in push order on consecutive cycles, ninth accepted once TREADY rises.
REQ-025 Issue beat slot2=WAIT cnt=3, then beat slot0=REF -> 3 idle beats with wait_busy=1, then ref[0]=1.
REQ-026 Issue slot0=PRE with pall=1 and slot1=ACT with A-bit=1 -> pall=4'b0001.
REQ-027 Assert rst_n=0 for one cycle during a WAIT cnt=100 countdown with 4 beats buffered -> fifo_level=0, wait_busy=0, idle beat, no buffered beat issued afterward.
REQ-028 Push and pop in the same cycle at level 3 -> level stays 3; with SLOTS=2 and FIFO_DEPTH=4, repeat REQ-023 and REQ-024 with proportionally scaled counts.

Source files
------------

// File: rtl/axi4_instr_q.sv
// Buffers AXI-Stream DDR command beats and issues one decoded beat per cycle; push-to-output 2 edges.
// S_AXIS_TREADY drops only when the FIFO is full; a WAIT countdown or issue_en=0 stalls issue and outputs idle beats.
module axi4_instr_q #(
  parameter int SLOTS      = 4,
  parameter int BG_WIDTH   = 2,
  parameter int BANK_WIDTH = 2,
  parameter int COL_WIDTH  = 10,
  parameter int ROW_WIDTH  = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [32*SLOTS-1:0]           S_AXIS_TDATA,
  input  logic                          S_AXIS_TVALID,
  output logic                          S_AXIS_TREADY,
  input  logic                          issue_en,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          wait_busy,
  output logic [2:0]                    latest_instr_id,
  output logic [SLOTS-1:0]              ddr_write,
  output logic [SLOTS-1:0]              ddr_read,
  output logic [SLOTS-1:0]              ddr_pre,
  output logic [SLOTS-1:0]              ddr_act,
  output logic [SLOTS-1:0]              ddr_ref,
  output logic [SLOTS-1:0]              ddr_zq,
  output logic [SLOTS-1:0]              ddr_nop,
  output logic [SLOTS-1:0]              ddr_ap,
  output logic [SLOTS-1:0]              ddr_half_bl,
  output logic [SLOTS-1:0]              ddr_pall,
  output logic [SLOTS*BG_WIDTH-1:0]     ddr_bg,
  output logic [SLOTS*BANK_WIDTH-1:0]   ddr_bank,
  output logic [SLOTS*COL_WIDTH-1:0]    ddr_col,
  output logic [SLOTS*ROW_WIDTH-1:0]    ddr_row
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int BW = 32 * SLOTS;
  localparam int A  = 3 + BANK_WIDTH + BG_WIDTH;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PRE  = 3'd1;
  localparam logic [2:0] OP_ACT  = 3'd2;
  localparam logic [2:0] OP_RD   = 3'd3;
  localparam logic [2:0] OP_WR   = 3'd4;
  localparam logic [2:0] OP_REF  = 3'd5;
  localparam logic [2:0] OP_ZQ   = 3'd6;
  localparam logic [2:0] OP_WAIT = 3'd7;

  logic [BW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [15:0]   wait_q;
  logic [BW-1:0] beat_q;
  logic          beat_vld_q;
  logic [BW-1:0] head;
  logic          push, pop;
  logic          wait_hit;
  logic [15:0]   wait_ld;

  assign head          = mem[rd_ptr];
  assign S_AXIS_TREADY = rst_n && (fifo_level != LW'(FIFO_DEPTH));
  assign push          = S_AXIS_TVALID && S_AXIS_TREADY;
  assign pop           = issue_en && (fifo_level != '0) && (wait_q == '0);
  assign wait_busy     = (wait_q != '0);

  // Highest-index WAIT slot wins, so scan upward and let later slots overwrite.
  always_comb begin
    wait_hit = 1'b0;
    wait_ld  = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (head[32*s +: 3] == OP_WAIT) begin
        wait_hit = 1'b1;
        wait_ld  = head[32*s+3 +: 16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= S_AXIS_TDATA;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      wait_q     <= '0;
      beat_vld_q <= 1'b0;
      beat_q     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (pop && wait_hit)  wait_q <= wait_ld;
      else if (wait_q != '0) wait_q <= wait_q - 16'd1;
      beat_vld_q <= pop;
      if (pop) beat_q <= head;
    end
  end

  logic [SLOTS-1:0]            n_write, n_read, n_pre, n_act, n_ref, n_zq, n_nop, n_ap, n_hbl, n_pall;
  logic [SLOTS*BG_WIDTH-1:0]   n_bg;
  logic [SLOTS*BANK_WIDTH-1:0] n_bank;
  logic [SLOTS*COL_WIDTH-1:0]  n_col;
  logic [SLOTS*ROW_WIDTH-1:0]  n_row;
  logic [2:0]                  op;

  always_comb begin
    n_write = '0; n_read = '0; n_pre = '0; n_act = '0; n_ref = '0; n_zq = '0;
    n_nop   = '1; n_ap   = '0; n_hbl = '0; n_pall = '0;
    n_bg    = '0; n_bank = '0; n_col = '0; n_row  = '0;
    op      = OP_NOP;
    if (beat_vld_q) begin
      n_nop = '0;
      for (int s = 0; s < SLOTS; s++) begin
        op = beat_q[32*s +: 3];
        case (op)
          OP_PRE: begin n_pre[s] = 1'b1; n_pall[s] = beat_q[32*s+A]; end
          OP_ACT: n_act[s] = 1'b1;
          OP_RD: begin
            n_read[s] = 1'b1;
            n_ap[s]   = beat_q[32*s+A+COL_WIDTH];
            n_hbl[s]  = beat_q[32*s+A+COL_WIDTH+1];
          end
          OP_WR: begin
            n_write[s] = 1'b1;
            n_ap[s]    = beat_q[32*s+A+COL_WIDTH];
            n_hbl[s]   = beat_q[32*s+A+COL_WIDTH+1];
          end
          OP_REF:  n_ref[s] = 1'b1;
          OP_ZQ:   n_zq[s]  = 1'b1;
          default: n_nop[s] = 1'b1;
        endcase
        if (op != OP_NOP && op != OP_WAIT) begin
          n_bank[s*BANK_WIDTH +: BANK_WIDTH] = beat_q[32*s+3 +: BANK_WIDTH];
          n_bg[s*BG_WIDTH +: BG_WIDTH]       = beat_q[32*s+3+BANK_WIDTH +: BG_WIDTH];
          n_row[s*ROW_WIDTH +: ROW_WIDTH]    = beat_q[32*s+A +: ROW_WIDTH];
          n_col[s*COL_WIDTH +: COL_WIDTH]    = beat_q[32*s+A +: COL_WIDTH];
        end
      end
    end
  end

  // Bits above the decoded fields of each slot are carried but never interpreted.
  logic unused_beat_bits;
  assign unused_beat_bits = ^beat_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ddr_write <= '0; ddr_read <= '0; ddr_pre <= '0; ddr_act <= '0; ddr_ref <= '0;
      ddr_zq    <= '0; ddr_nop  <= '1; ddr_ap  <= '0; ddr_half_bl <= '0; ddr_pall <= '0;
      ddr_bg    <= '0; ddr_bank <= '0; ddr_col <= '0; ddr_row <= '0;
      latest_instr_id <= '0;
    end else begin
      ddr_write <= n_write; ddr_read <= n_read; ddr_pre <= n_pre; ddr_act <= n_act;
      ddr_ref   <= n_ref;   ddr_zq   <= n_zq;   ddr_nop <= n_nop; ddr_ap  <= n_ap;
      ddr_half_bl <= n_hbl; ddr_pall <= n_pall;
      ddr_bg    <= n_bg;    ddr_bank <= n_bank; ddr_col <= n_col; ddr_row <= n_row;
      if (beat_vld_q) latest_instr_id <= beat_q[2:0];
    end
  end

endmodule

// File: tb/tb_axi4_instr_q.sv
// Scoreboard bench for axi4_instr_q: default instance plus a SLOTS=2/FIFO_DEPTH=4 instance.
module tb_axi4_instr_q;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [127:0] tdata;
  logic         tvalid, tready, issue_en, wbusy;
  logic [3:0]   level;
  logic [2:0]   iid;
  logic [3:0]   d_wr, d_rd, d_pre, d_act, d_ref, d_zq, d_nop, d_ap, d_hbl, d_pall;
  logic [7:0]   d_bg, d_bank;
  logic [39:0]  d_col;
  logic [67:0]  d_row;

  logic [63:0]  t2data;
  logic         t2valid, t2ready, t2issue, wbusy2;
  logic [2:0]   level2, iid2;
  logic [1:0]   e_wr, e_rd, e_pre, e_act, e_ref, e_zq, e_nop, e_ap, e_hbl, e_pall;
  logic [3:0]   e_bg, e_bank;
  logic [19:0]  e_col;
  logic [33:0]  e_row;

  axi4_instr_q dut (
    .clk(clk), .rst_n(rst_n), .S_AXIS_TDATA(tdata), .S_AXIS_TVALID(tvalid),
    .S_AXIS_TREADY(tready), .issue_en(issue_en), .fifo_level(level), .wait_busy(wbusy),
    .latest_instr_id(iid), .ddr_write(d_wr), .ddr_read(d_rd), .ddr_pre(d_pre), .ddr_act(d_act),
    .ddr_ref(d_ref), .ddr_zq(d_zq), .ddr_nop(d_nop), .ddr_ap(d_ap), .ddr_half_bl(d_hbl),
    .ddr_pall(d_pall), .ddr_bg(d_bg), .ddr_bank(d_bank), .ddr_col(d_col), .ddr_row(d_row)
  );

  axi4_instr_q #(.SLOTS(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .S_AXIS_TDATA(t2data), .S_AXIS_TVALID(t2valid),
    .S_AXIS_TREADY(t2ready), .issue_en(t2issue), .fifo_level(level2), .wait_busy(wbusy2),
    .latest_instr_id(iid2), .ddr_write(e_wr), .ddr_read(e_rd), .ddr_pre(e_pre), .ddr_act(e_act),
    .ddr_ref(e_ref), .ddr_zq(e_zq), .ddr_nop(e_nop), .ddr_ap(e_ap), .ddr_half_bl(e_hbl),
    .ddr_pall(e_pall), .ddr_bg(e_bg), .ddr_bank(e_bank), .ddr_col(e_col), .ddr_row(e_row)
  );

  typedef struct packed {
    logic [3:0]  wr, rd, pre, act, rf, zq, nop, ap, hbl, pall;
    logic [7:0]  bg, bank;
    logic [39:0] col;
    logic [67:0] row;
  } obs_t;

  typedef struct packed {
    obs_t       o;
    logic [2:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   issue_cyc_q[$];
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, issued = 0, busy_cnt = 0;
  bit   mon_en = 1'b0;
  obs_t mon_o;
  exp_t mon_e;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic obs_t idle_obs();
    obs_t o;
    o     = '0;
    o.nop = 4'hF;
    return o;
  endfunction

  function automatic obs_t cur_obs();
    obs_t o;
    o.wr = d_wr; o.rd = d_rd; o.pre = d_pre; o.act = d_act; o.rf = d_ref; o.zq = d_zq;
    o.nop = d_nop; o.ap = d_ap; o.hbl = d_hbl; o.pall = d_pall;
    o.bg = d_bg; o.bank = d_bank; o.col = d_col; o.row = d_row;
    return o;
  endfunction

  // Reference decode for the default field layout: op[2:0] bank[4:3] bg[6:5] row[23:7] col[16:7].
  function automatic obs_t model(input logic [127:0] b);
    obs_t o;
    logic [31:0] sl;
    o = '0;
    for (int s = 0; s < 4; s++) begin
      sl = b[32*s +: 32];
      case (sl[2:0])
        3'd1: begin o.pre[s] = 1'b1; o.pall[s] = sl[7]; end
        3'd2: o.act[s] = 1'b1;
        3'd3: begin o.rd[s] = 1'b1; o.ap[s] = sl[17]; o.hbl[s] = sl[18]; end
        3'd4: begin o.wr[s] = 1'b1; o.ap[s] = sl[17]; o.hbl[s] = sl[18]; end
        3'd5: o.rf[s] = 1'b1;
        3'd6: o.zq[s] = 1'b1;
        default: o.nop[s] = 1'b1;
      endcase
      if (sl[2:0] != 3'd0 && sl[2:0] != 3'd7) begin
        o.bank[2*s +: 2] = sl[4:3];
        o.bg[2*s +: 2]   = sl[6:5];
        o.col[10*s +: 10] = sl[16:7];
        o.row[17*s +: 17] = sl[23:7];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] slot_a(input logic [2:0] op, input logic [1:0] bank,
                                         input logic [1:0] bg, input logic [16:0] a);
    return {8'h0, a, bg, bank, op};
  endfunction

  function automatic logic [31:0] slot_w(input logic [15:0] cnt);
    return {13'h0, cnt, 3'd7};
  endfunction

  function automatic logic [127:0] rnd_beat();
    logic [127:0] b;
    logic [2:0]   op;
    for (int s = 0; s < 4; s++) begin
      op = (s == 0) ? 3'($urandom_range(6, 1)) : 3'($urandom_range(6, 0));
      b[32*s +: 32] = slot_a(op, 2'($urandom), 2'($urandom), 17'($urandom));
    end
    return b;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_o = cur_obs();
      if (wbusy) busy_cnt++;
      if (mon_o !== idle_obs()) begin
        issued++;
        issue_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 256'(mon_o), 256'(idle_obs()));
        end else begin
          mon_e = exp_q.pop_front();
          check("beat", 256'(mon_o), 256'(mon_e.o));
          check("instr_id", 256'(iid), 256'(mon_e.id));
        end
      end
    end
  end

  task automatic push(input int sel, input logic [127:0] d);
    int   t;
    exp_t e;
    t = 0;
    @(negedge clk);
    if (sel == 0) begin tdata = d; tvalid = 1'b1; end
    else begin t2data = d[63:0]; t2valid = 1'b1; end
    while (((sel == 0) ? tready : t2ready) !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      check("push_ready", 256'((sel == 0) ? tready : t2ready), 256'(1));
    end else if (sel == 0) begin
      e.o  = model(d);
      e.id = d[2:0];
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    check("drain", 256'(exp_q.size()), 256'(0));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] b;
    int n0;
    rst_n = 1'b0; tdata = '0; tvalid = 1'b0; issue_en = 1'b0;
    t2data = '0; t2valid = 1'b0; t2issue = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_level", 256'(level), 256'(0));
    check("rst_busy", 256'(wbusy), 256'(0));
    check("rst_iid", 256'(iid), 256'(0));
    check("rst_tready", 256'(tready), 256'(0));
    check("rst_tready2", 256'(t2ready), 256'(0));
    check("rst_idle", 256'(cur_obs()), 256'(idle_obs()));
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_tready", 256'(tready), 256'(1));
    mon_en = 1'b1;

    // Single beat latency and field decode
    issue_en = 1'b1;
    b = {32'h0, 32'h0, slot_a(3'd3, 2'd0, 2'd0, 17'h00555), slot_a(3'd2, 2'd2, 2'd1, 17'h1ABCD)};
    push(0, b);
    tvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("lat_idle", 256'(d_nop), 256'(4'hF));
    @(negedge clk);
    check("act0", 256'(d_act[0]), 256'(1));
    check("read1", 256'(d_rd[1]), 256'(1));
    check("ap1", 256'(d_ap[1]), 256'(1));
    check("nop32", 256'(d_nop[3:2]), 256'(2'b11));
    check("row0", 256'(d_row[16:0]), 256'(17'h1ABCD));
    check("bank0", 256'(d_bank[1:0]), 256'(2));
    check("bg0", 256'(d_bg[1:0]), 256'(1));
    check("col1", 256'(d_col[19:10]), 256'(10'h155));
    drain();

    // Fill to full with issue held off, then release
    issue_en = 1'b0;
    issue_cyc_q.delete();
    for (int i = 0; i < 8; i++) push(0, rnd_beat());
    b = rnd_beat();
    tdata = b;
    @(negedge clk);
    check("full_level", 256'(level), 256'(8));
    check("full_tready", 256'(tready), 256'(0));
    issue_en = 1'b1;
    push(0, b);
    tvalid = 1'b0;
    drain();
    check("burst_count", 256'(issue_cyc_q.size()), 256'(9));
    if (issue_cyc_q.size() >= 8)
      for (int i = 0; i < 7; i++)
        check("burst_consec", 256'(issue_cyc_q[i+1] - issue_cyc_q[i]), 256'(1));

    // WAIT insertion: highest WAIT slot wins, zero count inserts nothing
    issue_en = 1'b0;
    push(0, {slot_a(3'd3, 2'd1, 2'd2, 17'h00321), slot_w(16'd3), slot_w(16'd9),
             slot_a(3'd1, 2'd3, 2'd0, 17'h00100)});
    push(0, {32'h0, 32'h0, 32'h0, slot_a(3'd5, 2'd1, 2'd2, 17'h00000)});
    push(0, {slot_w(16'd0), 32'h0, 32'h0, slot_a(3'd6, 2'd0, 2'd1, 17'h00007)});
    push(0, {32'h0, 32'h0, 32'h0, slot_a(3'd2, 2'd3, 2'd3, 17'h0F0F0)});
    tvalid = 1'b0;
    issue_cyc_q.delete();
    busy_cnt = 0;
    @(negedge clk);
    issue_en = 1'b1;
    drain();
    check("wait_issues", 256'(issue_cyc_q.size()), 256'(4));
    if (issue_cyc_q.size() == 4) begin
      check("wait_gap3", 256'(issue_cyc_q[1] - issue_cyc_q[0]), 256'(4));
      check("wait_gap0", 256'(issue_cyc_q[2] - issue_cyc_q[1]), 256'(1));
      check("nowait_gap", 256'(issue_cyc_q[3] - issue_cyc_q[2]), 256'(1));
    end
    check("wait_busy_cycles", 256'(busy_cnt), 256'(3));
    check("iid_hold", 256'(iid), 256'(3'd2));

    // pall only on PRE, half_bl only on RD/WR
    push(0, {slot_a(3'd6, 2'd0, 2'd0, 17'h00001), slot_a(3'd4, 2'd0, 2'd0, 17'h00801),
             slot_a(3'd2, 2'd2, 2'd3, 17'h00001), slot_a(3'd1, 2'd1, 2'd0, 17'h00001)});
    tvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("pall", 256'(d_pall), 256'(4'b0001));
    check("half_bl", 256'(d_hbl), 256'(4'b0100));
    drain();

    // Simultaneous push and pop keeps the level
    issue_en = 1'b0;
    for (int i = 0; i < 3; i++) push(0, rnd_beat());
    issue_en = 1'b1;
    push(0, rnd_beat());
    check("pushpop_level", 256'(level), 256'(3));
    tvalid = 1'b0;
    drain();

    // Reset during a long WAIT with beats buffered
    push(0, {32'h0, 32'h0, slot_w(16'd100), slot_a(3'd2, 2'd1, 2'd1, 17'h00ABC)});
    for (int i = 0; i < 4; i++) push(0, rnd_beat());
    tvalid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_level", 256'(level), 256'(4));
    check("mid_busy", 256'(wbusy), 256'(1));
    check("mid_pending", 256'(exp_q.size()), 256'(4));
    while (exp_q.size() != 0) void'(exp_q.pop_back());
    rst_n = 1'b0;
    #1;
    check("rst2_tready", 256'(tready), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst2_level", 256'(level), 256'(0));
    check("rst2_busy", 256'(wbusy), 256'(0));
    check("rst2_iid", 256'(iid), 256'(0));
    check("rst2_idle", 256'(cur_obs()), 256'(idle_obs()));
    check("rst2_tready_rel", 256'(tready), 256'(1));
    n0 = issued;
    repeat (130) @(negedge clk);
    check("rst2_no_issue", 256'(issued - n0), 256'(0));

    // Small instance: latency/decode and fill/drain scaled to 2 slots, depth 4
    t2issue = 1'b1;
    push(1, {64'h0, slot_a(3'd3, 2'd0, 2'd0, 17'h00555), slot_a(3'd2, 2'd2, 2'd1, 17'h1ABCD)});
    t2valid = 1'b0;
    repeat (2) @(negedge clk);
    check("s2_lat_idle", 256'(e_nop), 256'(2'b11));
    @(negedge clk);
    check("s2_act0", 256'(e_act[0]), 256'(1));
    check("s2_read1", 256'(e_rd[1]), 256'(1));
    check("s2_ap1", 256'(e_ap[1]), 256'(1));
    check("s2_row0", 256'(e_row[16:0]), 256'(17'h1ABCD));
    check("s2_col1", 256'(e_col[19:10]), 256'(10'h155));
    repeat (2) @(negedge clk);
    t2issue = 1'b0;
    for (int i = 1; i <= 4; i++)
      push(1, {64'h0, slot_a(3'd6, 2'd0, 2'd0, 17'h0), slot_a(3'd2, 2'(i), 2'd0, 17'(i))});
    t2data = {slot_a(3'd6, 2'd0, 2'd0, 17'h0), slot_a(3'd2, 2'd1, 2'd0, 17'd5)};
    repeat (2) @(negedge clk);
    check("s2_full_level", 256'(level2), 256'(4));
    check("s2_full_tready", 256'(t2ready), 256'(0));
    t2issue = 1'b1;
    push(1, {64'h0, slot_a(3'd6, 2'd0, 2'd0, 17'h0), slot_a(3'd2, 2'd1, 2'd0, 17'd5)});
    t2valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("s2_order_row", 256'(e_row[16:0]), 256'(i));
      check("s2_order_act", 256'(e_act), 256'(2'b01));
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
